ram_loader: RTL

- Writes a complete program image into the CPU's RAM from a byte stream, checks it, then releases the CPU to run.
- While loading it holds the CPU halted and drives the RAM control strobes itself: address latch, write, read.
- Image format: 2^ADDRESS_WIDTH data words followed by one checksum word.
- After writing, it reads every word back and compares the sum read against the sum written.

---
 rtl/ram_loader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : ram_loader
// Description : Takes a program image from a byte stream, writes it into the
//               CPU RAM, reads it back to confirm it, and then lets the CPU
//               run. The image is 2^ADDRESS_WIDTH data words followed by one
//               checksum word. The loader keeps the CPU halted and drives the
//               RAM strobes for the whole load and verify.
// Ports       : clk             - system clock, all state changes on posedge
//               rst_n           - asynchronous active-low reset
//               start_i         - one-cycle pulse that starts a load (IDLE/DONE/ERROR)
//               in_data_i       - stream word
//               in_valid_i      - in_data_i is valid
//               in_ready_o      - a stream word is accepted this cycle
//               mem_addr_en_o   - RAM address latch strobe (mi)
//               mem_write_en_o  - RAM write strobe (ri)
//               mem_read_en_o   - RAM output enable (ro)
//               mem_bus_o       - value driven onto the RAM bus_in
//               mem_rd_data_i   - RAM bus_out
//               cpu_hold_o      - 1 = the CPU control clock must stay halted
//               busy_o          - a load or verify is in progress
//               done_o          - the last load passed (sticky until start)
//               error_o         - the last load failed (sticky until start)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_loader #(
  parameter int WIDTH         = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             mem_addr_en_o,
  output logic             mem_write_en_o,
  output logic             mem_read_en_o,
  output logic [WIDTH-1:0] mem_bus_o,
  input  logic [WIDTH-1:0] mem_rd_data_i,
  output logic             cpu_hold_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RECV  = 4'd1,
    S_WADDR = 4'd2,
    S_WRITE = 4'd3,
    S_CHK   = 4'd4,
    S_VADDR = 4'd5,
    S_VREAD = 4'd6,
    S_DONE  = 4'd7,
    S_ERROR = 4'd8
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] c_ADDR_LAST = '1;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]         data_q, data_d;
  logic [WIDTH-1:0]         sum_wr_q, sum_wr_d;
  logic [WIDTH-1:0]         sum_rd_q, sum_rd_d;

  // Running sums are kept at word width so they wrap modulo 2^WIDTH.
  logic [WIDTH-1:0] w_wr_sum;
  logic [WIDTH-1:0] w_rd_sum;
  logic [WIDTH-1:0] w_addr_ext;

  assign w_wr_sum   = sum_wr_q + in_data_i;
  assign w_rd_sum   = sum_rd_q + mem_rd_data_i;
  assign w_addr_ext = WIDTH'(addr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      sum_wr_q <= '0;
      sum_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      sum_wr_q <= sum_wr_d;
      sum_rd_q <= sum_rd_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    data_d         = data_q;
    sum_wr_d       = sum_wr_q;
    sum_rd_d       = sum_rd_q;
    in_ready_o     = 1'b0;
    mem_addr_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    mem_read_en_o  = 1'b0;
    mem_bus_o      = '0;
    busy_o         = 1'b1;
    done_o         = 1'b0;
    error_o        = 1'b0;
    cpu_hold_o     = 1'b1;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        busy_o = 1'b0;
        if (state_q == S_IDLE) begin
          // IDLE is reachable only from reset, so the reset hold value applies.
          cpu_hold_o = HOLD_AT_RESET;
        end else if (state_q == S_DONE) begin
          cpu_hold_o = 1'b0;
          done_o     = 1'b1;
        end else begin
          error_o    = 1'b1;
        end
        if (start_i) begin
          state_d  = S_RECV;
          addr_d   = '0;
          sum_wr_d = '0;
          sum_rd_d = '0;
        end
      end
      S_RECV: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          data_d   = in_data_i;
          sum_wr_d = w_wr_sum;
          state_d  = S_WADDR;
        end
      end
      S_WADDR: begin
        mem_addr_en_o = 1'b1;
        mem_bus_o     = w_addr_ext;
        state_d       = S_WRITE;
      end
      S_WRITE: begin
        mem_write_en_o = 1'b1;
        mem_bus_o      = data_q;
        // The address wraps to zero after the last word, which is where verify starts.
        addr_d         = addr_q + 1'b1;
        state_d        = (addr_q == c_ADDR_LAST) ? S_CHK : S_RECV;
      end
      S_CHK: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          state_d = (w_wr_sum == '0) ? S_VADDR : S_ERROR;
        end
      end
      S_VADDR: begin
        mem_addr_en_o = 1'b1;
        mem_bus_o     = w_addr_ext;
        state_d       = S_VREAD;
      end
      S_VREAD: begin
        mem_read_en_o = 1'b1;
        sum_rd_d      = w_rd_sum;
        addr_d        = addr_q + 1'b1;
        if (addr_q == c_ADDR_LAST) begin
          // Compare using the sum that includes this last word.
          state_d = (w_rd_sum == sum_wr_q) ? S_DONE : S_ERROR;
        end else begin
          state_d = S_VADDR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
